// File: rtl/csr_ctrl_if.sv
// Pipeline CSR access, trap entry and CSR file port bundle for csr_ctrl.
interface csr_ctrl_if;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic              csr_req;
  logic [1:0]        csr_op;
  logic [ADDR_W-1:0] csr_addr;
  logic [DATA_W-1:0] csr_wdata;
  logic              csr_ready;
  logic [DATA_W-1:0] csr_rdata;

  logic              trap_req;
  logic [DATA_W-1:0] trap_pc;
  logic [DATA_W-1:0] trap_cause;
  logic [DATA_W-1:0] trap_val;
  logic              trap_busy;
  logic              trap_done;

  logic [ADDR_W-1:0] rf_addr;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  // Pipeline / trap source and CSR file side
  modport master (
    output csr_req, csr_op, csr_addr, csr_wdata,
    input  csr_ready, csr_rdata,
    output trap_req, trap_pc, trap_cause, trap_val,
    input  trap_busy, trap_done,
    input  rf_addr, rf_we, rf_wdata,
    output rf_rdata
  );

  // Controller side
  modport slave (
    input  csr_req, csr_op, csr_addr, csr_wdata,
    output csr_ready, csr_rdata,
    input  trap_req, trap_pc, trap_cause, trap_val,
    output trap_busy, trap_done,
    output rf_addr, rf_we, rf_wdata,
    input  rf_rdata
  );
endinterface

// File: rtl/csr_ctrl.sv
// CSR access controller: read-modify-write of a single-port CSR file plus
// the trap-entry write sequence (mepc, mcause and optionally mtval).
// Build option: define CSR_TRAP_TVAL_EN to add the mtval write to the trap
// sequence; otherwise trap_done pulses on the mcause write.
module csr_ctrl #(
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MTVAL_ADDR  = 12'h343
) (
  input logic         clk,
  input logic         rst_n,
  csr_ctrl_if.slave   bus
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CSR_RD,
    CSR_WR,
    TRAP_EPC,
    TRAP_CAUSE
`ifdef CSR_TRAP_TVAL_EN
    , TRAP_TVAL
`endif
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pending_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] cause_q;
`ifdef CSR_TRAP_TVAL_EN
  logic [DATA_W-1:0] tval_q;
`endif

  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic              rf_we_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic [DATA_W-1:0] new_val_c;
  logic              need_we_c;
  logic              trap_new_c;
  logic              trap_go_c;
  logic [DATA_W-1:0] epc_data_c;

  // Modified CSR value and whether the file actually needs a write
  always_comb begin
    new_val_c = wdata_q;
    need_we_c = (op_q == OP_RW) || (wdata_q != '0);
    case (op_q)
      OP_RS:   new_val_c = bus.rf_rdata | wdata_q;
      OP_RC:   new_val_c = bus.rf_rdata & ~wdata_q;
      default: new_val_c = wdata_q;
    endcase
  end

  // A fresh trap is only taken when no trap is pending or running
  always_comb begin
    trap_new_c = bus.trap_req && !busy_q;
    trap_go_c  = trap_new_c || pending_q;
    epc_data_c = pending_q ? pc_q : bus.trap_pc;
  end

  // Sequencer: state, latched request/trap data and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      pending_q  <= 1'b0;
      pc_q       <= '0;
      cause_q    <= '0;
`ifdef CSR_TRAP_TVAL_EN
      tval_q     <= '0;
`endif
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rf_addr_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_wdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;

      if (trap_new_c) begin
        pc_q    <= bus.trap_pc;
        cause_q <= bus.trap_cause;
`ifdef CSR_TRAP_TVAL_EN
        tval_q  <= bus.trap_val;
`endif
        busy_q  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trap_go_c) begin
            state      <= TRAP_EPC;
            pending_q  <= 1'b0;
            rf_addr_q  <= MEPC_ADDR;
            rf_we_q    <= 1'b1;
            rf_wdata_q <= epc_data_c;
          end else if (bus.csr_req && !ready_q) begin
            if (bus.csr_op == OP_NOP) begin
              ready_q <= 1'b1;
            end else begin
              op_q       <= bus.csr_op;
              addr_q     <= bus.csr_addr;
              wdata_q    <= bus.csr_wdata;
              state      <= CSR_RD;
              rf_addr_q  <= bus.csr_addr;
              rf_we_q    <= 1'b0;
              rf_wdata_q <= '0;
            end
          end
        end

        CSR_RD: begin
          if (trap_new_c) pending_q <= 1'b1;
          rdata_q    <= bus.rf_rdata;
          state      <= CSR_WR;
          rf_addr_q  <= addr_q;
          rf_we_q    <= need_we_c;
          rf_wdata_q <= new_val_c;
          ready_q    <= 1'b1;
        end

        CSR_WR: begin
          if (trap_go_c) begin
            state      <= TRAP_EPC;
            pending_q  <= 1'b0;
            rf_addr_q  <= MEPC_ADDR;
            rf_we_q    <= 1'b1;
            rf_wdata_q <= epc_data_c;
          end else begin
            state      <= IDLE;
            rf_addr_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
          end
        end

        TRAP_EPC: begin
          state      <= TRAP_CAUSE;
          rf_addr_q  <= MCAUSE_ADDR;
          rf_we_q    <= 1'b1;
          rf_wdata_q <= cause_q;
`ifndef CSR_TRAP_TVAL_EN
          done_q     <= 1'b1;
`endif
        end

`ifdef CSR_TRAP_TVAL_EN
        TRAP_CAUSE: begin
          state      <= TRAP_TVAL;
          rf_addr_q  <= MTVAL_ADDR;
          rf_we_q    <= 1'b1;
          rf_wdata_q <= tval_q;
          done_q     <= 1'b1;
        end

        TRAP_TVAL: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          rf_addr_q  <= '0;
          rf_we_q    <= 1'b0;
          rf_wdata_q <= '0;
        end
`else
        TRAP_CAUSE: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          rf_addr_q  <= '0;
          rf_we_q    <= 1'b0;
          rf_wdata_q <= '0;
        end
`endif

        default: begin
          state      <= IDLE;
          rf_addr_q  <= '0;
          rf_we_q    <= 1'b0;
          rf_wdata_q <= '0;
        end
      endcase
    end
  end

  assign bus.csr_ready = ready_q;
  assign bus.csr_rdata = rdata_q;
  assign bus.trap_busy = busy_q;
  assign bus.trap_done = done_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 SHALL have parameter MEPC_ADDR, default 12'h341, target address of the trap PC write.
REQ-002 SHALL have parameter MCAUSE_ADDR, default 12'h342, target address of the trap cause write.
REQ-003 SHALL have parameter MTVAL_ADDR, default 12'h343, target address of the trap value write.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 csr_req  in  1  pipeline CSR access request; held until csr_ready.
REQ-008 csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no operation.
REQ-009 csr_addr  in  12  CSR address.
REQ-010 csr_wdata  in  32  source operand (rs1 or immediate).
REQ-011 csr_ready  out  1  one-cycle completion pulse.
REQ-012 csr_rdata  out  32  old CSR value, valid with csr_ready and held afterwards.
REQ-013 trap_req  in  1  trap entry pulse.
REQ-014 trap_pc, trap_cause, trap_val  in  32 each  trap write data.
REQ-015 trap_busy  out  1  high while a trap sequence is pending or running.
REQ-016 trap_done  out  1  one-cycle pulse on the final trap write.
REQ-017 rf_addr  out  12  CSR file single-port address.
REQ-018 rf_we  out  1  CSR file write enable.
REQ-019 rf_wdata  out  32  CSR file write data.
REQ-020 rf_rdata  in  32  CSR file combinational read data.

Function
REQ-021 SHALL implement the states IDLE, CSR_RD, CSR_WR, TRAP_EPC, TRAP_CAUSE and TRAP_TVAL.
REQ-022 In IDLE, a trap (trap_req or the pending flag) SHALL take priority over csr_req when both are present and SHALL go to TRAP_EPC.
REQ-023 In IDLE, csr_req with csr_op!=00 SHALL latch op, address and data, then go to CSR_RD.
REQ-024 csr_req with csr_op==00 SHALL produce csr_ready the next cycle, with no file access and csr_rdata unchanged.
REQ-025 In CSR_RD, the block SHALL drive rf_addr with the latched address and rf_we=0, capture rf_rdata into csr_rdata, and go to CSR_WR.
REQ-026 In CSR_WR, new value = RW: wdata; RS: old|wdata; RC: old&~wdata.
REQ-027 In CSR_WR, the block SHALL assert rf_we, pulse csr_ready, and return to IDLE.
REQ-028 For RS or RC with wdata==0, rf_we SHALL stay 0 in CSR_WR; csr_ready SHALL still pulse.
REQ-029 Accept-to-csr_ready latency SHALL be exactly 2 cycles with no contention.
REQ-030 trap_req arriving in any non-IDLE state SHALL set a pending flag; an in-flight CSR access SHALL complete before the trap starts.
REQ-031 trap_req while a trap is already pending or running SHALL be ignored.
REQ-032 Trap data SHALL be latched when trap_req is sampled.
REQ-033 TRAP_EPC SHALL write trap_pc to MEPC_ADDR; TRAP_CAUSE SHALL write trap_cause to MCAUSE_ADDR; TRAP_TVAL SHALL write trap_val to MTVAL_ADDR. Each is one cycle with rf_we=1.
REQ-034 trap_done SHALL pulse in the last trap state, which SHALL then return to IDLE.
REQ-035 trap_busy SHALL be 1 from the cycle after trap_req is sampled through the trap_done cycle inclusive.
REQ-036 rf_we SHALL be 0 in IDLE and CSR_RD; rf_addr and rf_wdata SHALL be 0 in IDLE.
REQ-037 csr_req held through a trap SHALL be accepted in the first IDLE cycle after trap_done.

Reset
REQ-038 rst_n low SHALL immediately force IDLE, clear the pending flag, and zero csr_ready, csr_rdata, trap_busy, trap_done, rf_we, rf_addr and rf_wdata.
REQ-039 Reset mid-sequence SHALL abandon the sequence; no rf_we SHALL occur until a new request is accepted after rst_n rises.

Configuration
REQ-040 Macro CSR_TRAP_TVAL_EN defined: the trap sequence SHALL be EPC, CAUSE, TVAL (3 writes), with trap_done in TRAP_TVAL.
REQ-041 Macro CSR_TRAP_TVAL_EN undefined: the TRAP_TVAL state SHALL be absent, trap_val SHALL be ignored, and trap_done SHALL pulse in TRAP_CAUSE after 2 writes.

Verification
REQ-042 CSR 12'h300 holds 32'h0000_0008; RS with wdata 32'h0000_0080 -> csr_rdata 32'h8, then 32'h88 written, csr_ready 2 cycles after accept.
REQ-043 RC on 12'h300 with wdata 0 -> csr_ready pulses, rf_we never asserted, csr_rdata = old value.
REQ-044 trap_req and csr_req in the same IDLE cycle with pc 32'h100, cause 32'hB, val 32'h0 -> writes to 341/342/343 on 3 consecutive cycles, trap_done, then the CSR access completes.
REQ-045 trap_req during CSR_RD -> CSR_WR completes, then the trap sequence starts the following cycle; a second trap_req during trap_busy is ignored.
REQ-046 rst_n low in TRAP_CAUSE -> all outputs 0 immediately, no further rf_we.
REQ-047 Build without CSR_TRAP_TVAL_EN -> exactly 2 trap writes, trap_done on the MCAUSE write.
